// File: rtl/tsi_cmd_pkg.sv
// tsi_cmd_pkg: shared states, command defaults and word sizes for the TSI command engine
package tsi_cmd_pkg;
  localparam int TSI_WORD_W = 32;
  localparam int HDR_WORDS = 5;
  localparam logic [TSI_WORD_W-1:0] DEF_CMD_READ = 32'd0;
  localparam logic [TSI_WORD_W-1:0] DEF_CMD_WRITE = 32'd1;
  typedef enum logic [3:0] {
    S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI,
    S_WR_DATA, S_WR_REQ, S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_ACK
  } state_t;
  function automatic logic takes_input(state_t s);
    return s inside {S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_WR_DATA};
  endfunction
endpackage

// File: rtl/tsi_burst_ctr.sv
// tsi_burst_ctr: burst word countdown and word-address stepper
module tsi_burst_ctr #(
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [63:0]       load_rem,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [63:0] rem;
  assign last = rem == 64'd0;
  // load on header completion; each step advances one word, the count holds at zero
  always_ff @(posedge clock)
    if (reset) begin
      rem <= '0;
      addr <= '0;
    end else if (load) begin
      rem <= load_rem;
      addr <= load_addr;
    end else if (step) begin
      rem <= last ? rem : rem - 64'd1;
      addr <= addr + ADDR_W'(4);
    end
endmodule

// File: rtl/tsi_cmd_engine.sv
// tsi_cmd_engine: parses TSI read/write commands into word memory requests; TSI_CMD_ENGINE_WR_ACK_EN adds a write-count ack word
module tsi_cmd_engine
  import tsi_cmd_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter logic [TSI_WORD_W-1:0] CMD_READ = DEF_CMD_READ,
  parameter logic [TSI_WORD_W-1:0] CMD_WRITE = DEF_CMD_WRITE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tsi_in_valid,
  output logic                  tsi_in_ready,
  input  logic [TSI_WORD_W-1:0] tsi_in_bits,
  output logic                  tsi_out_valid,
  input  logic                  tsi_out_ready,
  output logic [TSI_WORD_W-1:0] tsi_out_bits,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [TSI_WORD_W-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [TSI_WORD_W-1:0] mem_resp_rdata,
  output logic                  cmd_error
);
`ifdef TSI_CMD_ENGINE_WR_ACK_EN
  localparam state_t WR_DONE = S_ACK;
`else
  localparam state_t WR_DONE = S_CMD;
`endif
  state_t state, state_n;
  logic in_rdy_q, is_wr, in_fire, cmd_ok, step, last, load;
  logic [31:0] addr_lo, addr_hi, len_lo;
  logic [63:0] addr_full;
  assign tsi_in_ready = in_rdy_q;
  assign in_fire = tsi_in_valid && in_rdy_q;
  assign cmd_ok = tsi_in_bits == CMD_READ || tsi_in_bits == CMD_WRITE;
  assign addr_full = {addr_hi, addr_lo};
  assign load = in_fire && state == S_LEN_HI;
  assign mem_req_valid = state == S_WR_REQ || state == S_RD_REQ;
  assign mem_req_we = state == S_WR_REQ;
  assign tsi_out_valid = state == S_RD_SEND || state == S_ACK;
  assign step = (state == S_WR_REQ && mem_req_ready) || (state == S_RD_SEND && tsi_out_ready);
  tsi_burst_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clock(clock),
    .reset(reset),
    .load(load),
    .load_rem({tsi_in_bits, len_lo}),
    .load_addr(addr_full[ADDR_W-1:0]),
    .step(step),
    .addr(mem_req_addr),
    .last(last)
  );
  // next-state: header words advance on transfer, burst states on their handshakes
  always_comb begin
    state_n = state;
    case (state)
      S_CMD:     state_n = in_fire && cmd_ok ? S_ADDR_LO : S_CMD;
      S_ADDR_LO: state_n = in_fire ? S_ADDR_HI : state;
      S_ADDR_HI: state_n = in_fire ? S_LEN_LO : state;
      S_LEN_LO:  state_n = in_fire ? S_LEN_HI : state;
      S_LEN_HI:  state_n = !in_fire ? state : is_wr ? S_WR_DATA : S_RD_REQ;
      S_WR_DATA: state_n = in_fire ? S_WR_REQ : state;
      S_WR_REQ:  state_n = !mem_req_ready ? state : last ? WR_DONE : S_WR_DATA;
      S_RD_REQ:  state_n = mem_req_ready ? S_RD_WAIT : state;
      S_RD_WAIT: state_n = mem_resp_valid ? S_RD_SEND : state;
      S_RD_SEND: state_n = !tsi_out_ready ? state : last ? S_CMD : S_RD_REQ;
      S_ACK:     state_n = tsi_out_ready ? S_CMD : state;
      default:   state_n = S_CMD;
    endcase
  end
  // state, registered input ready, header latches and data registers
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_CMD;
      in_rdy_q <= 1'b0;
      is_wr <= 1'b0;
      cmd_error <= 1'b0;
      addr_lo <= '0;
      addr_hi <= '0;
      len_lo <= '0;
      mem_req_wdata <= '0;
      tsi_out_bits <= '0;
    end else begin
      state <= state_n;
      in_rdy_q <= takes_input(state_n);
      if (in_fire && state == S_CMD) is_wr <= tsi_in_bits == CMD_WRITE;
      if (in_fire && state == S_CMD && !cmd_ok) cmd_error <= 1'b1;
      if (in_fire && state == S_ADDR_LO) addr_lo <= tsi_in_bits;
      if (in_fire && state == S_ADDR_HI) addr_hi <= tsi_in_bits;
      if (in_fire && state == S_LEN_LO) len_lo <= tsi_in_bits;
      if (in_fire && state == S_WR_DATA) mem_req_wdata <= tsi_in_bits;
      if (state == S_RD_WAIT && mem_resp_valid) tsi_out_bits <= mem_resp_rdata;
`ifdef TSI_CMD_ENGINE_WR_ACK_EN
      if (state == S_WR_REQ && mem_req_ready && last) tsi_out_bits <= len_lo + 32'd1;
`endif
    end
endmodule

// File: doc/tsi_cmd_engine.md
Name: tsi_cmd_engine

Overview:
- Sits directly downstream of the host-side TSI bridge, on its 32-bit host-to-target word stream (tsi_in), and drives the return stream (tsi_out).
- Parses TSI commands into word-granular memory requests: a read produces returned data words; a write consumes payload words.
- Exposes a simple single-outstanding request/response memory port for the target-side interconnect adapter.

Parameters:
- ADDR_W, 64, memory address width; the 64-bit TSI address is truncated to its low ADDR_W bits.
- CMD_READ, 0, command word value for a read.
- CMD_WRITE, 1, command word value for a write.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- tsi_in_valid  in  1  host word valid
- tsi_in_ready  out  1  engine accepts host word
- tsi_in_bits  in  32  host word
- tsi_out_valid  out  1  response word valid
- tsi_out_ready  in  1  host accepts response word
- tsi_out_bits  out  32  response word
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  ADDR_W  word address (byte address, 4-aligned by construction)
- mem_req_wdata  out  32  write data
- mem_resp_valid  in  1  single-cycle read-data pulse; no ready
- mem_resp_rdata  in  32  read data
- cmd_error  out  1  sticky flag: unknown command seen

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Host word order: cmd, addr_lo, addr_hi, len_lo, len_hi, then for writes len+1 data words. len is the word count minus 1 (64-bit).
- States: CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, WR_DATA, WR_REQ, RD_REQ, RD_WAIT, RD_SEND, plus ACK (see Optional Feature).
- tsi_in_ready = 1 only in CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI and WR_DATA. A word transfers when valid && ready; each state advances on transfer.
- CMD:
  - CMD_READ or CMD_WRITE: latch the command and go to ADDR_LO.
  - Any other value: set cmd_error and stay in CMD (word dropped).
- LEN_HI:
  - Write goes to WR_DATA.
  - Read goes to RD_REQ.
  - remaining counter = {len_hi, len_lo}.
- WR_DATA: latch the word into mem_req_wdata, go to WR_REQ.
- WR_REQ:
  - mem_req_valid = 1, we = 1. Hold valid and all req fields stable until ready.
  - On handshake: addr += 4 (wraps modulo 2^ADDR_W).
  - If remaining == 0, go to CMD (ACK if enabled); else remaining -= 1 and go to WR_DATA.
- RD_REQ: mem_req_valid = 1, we = 0; on handshake go to RD_WAIT.
- RD_WAIT: on mem_resp_valid, latch rdata into tsi_out_bits and go to RD_SEND. mem_resp_valid outside RD_WAIT is ignored.
- RD_SEND:
  - tsi_out_valid = 1, held stable until ready.
  - On handshake: addr += 4.
  - If remaining == 0, go to CMD; else remaining -= 1 and go to RD_REQ.
- Latency: all outputs are registered or decoded from state only; no combinational in-to-out paths.
  - Read: first tsi_out_valid ≥3 cycles after len_hi acceptance (RD_REQ, RD_WAIT, RD_SEND minimum).
  - Write: one mem request per 2 cycles minimum.
- len = 2^64-1: the 64-bit counter runs without overflow; remaining == 0 is the sole termination.
- Reset, including mid-burst: state = CMD; mem_req_valid, tsi_out_valid, tsi_in_ready, cmd_error, mem_req_we = 0; addr, wdata, tsi_out_bits, remaining = 0. A partial burst is dropped. A read response already in flight is ignored after reset.

Optional Feature:
- Macro: TSI_CMD_ENGINE_WR_ACK_EN.
- Defined: after the final write handshake go to ACK; drive tsi_out_valid = 1 with tsi_out_bits = number of words written (low 32 bits of len+1); on handshake go to CMD.
- Undefined: no ACK state; writes return nothing on tsi_out.

Decomposition:
- Package tsi_cmd_pkg holds:
  - the state enum;
  - CMD_READ/CMD_WRITE defaults;
  - TSI_WORD_W = 32;
  - the header word count (5).
- One sub-module, tsi_burst_ctr: loads the 64-bit remaining count and ADDR_W address, then decrements and increments on a step pulse; exposes last = (remaining == 0).

Test Plan:
- Write of 2 words:
  - Stimulus: cmd=1, addr=0x1000_0000_0000_0080, len=1, data 0xAAAA0001 and 0xAAAA0002.
  - Response: two write requests, at addr 0x...80 then 0x...84, with matching data; no tsi_out activity (ACK=2 when enabled).
- Read of 3 words:
  - Stimulus: cmd=0, addr=0x100, len=2; memory returns 0x11, 0x22, 0x33.
  - Response: requests at 0x100, 0x104, 0x108; tsi_out carries 0x11, 0x22, 0x33 in order.
- Backpressure:
  - Stimulus: mem_req_ready low 5 cycles and tsi_out_ready low 4 cycles, during the read test.
  - Response: valid and fields held stable throughout; no word lost or duplicated.
- Bad command:
  - Stimulus: cmd=7, then a valid 1-word read.
  - Response: cmd_error=1 and remains 1; the read completes normally.
- Address wrap:
  - Stimulus: ADDR_W=32, write at 0xFFFF_FFFC with len=1.
  - Response: second request at address 0x0000_0000.
- Reset mid-read:
  - Stimulus: assert reset in RD_WAIT; a stale mem_resp_valid arrives after reset; then a new read.
  - Response: all outputs at reset values, stale response ignored, new read returns the correct data.
